dl11_uart_ctrl: RTL and testbench

DL11-style console register controller that sits between the DCJ11 bus-side decode logic and the `uart_tx`/`uart_rx` pair. It exposes four 16-bit registers: RCSR, RBUF, XCSR and XBUF. It sequences the transmitter send handshake and clears the receiver on RBUF reads. It also generates level interrupt requests that are cleared by an interrupt acknowledge.

---
 rtl/dl11_uart_ctrl.sv | 145 ++++++++++++++
 tb/tb_dl11_uart_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dl11_uart_ctrl.sv
// DL11-style console register block: RCSR/RBUF/XCSR/XBUF decode, uart_tx send
// handshake with timeout, and level interrupt requests with acknowledge.
module dl11_uart_ctrl #(
  parameter int TX_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_sel,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_byte_en,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rx_irq,
  output logic        o_tx_irq,
  input  logic        i_rx_iack,
  input  logic        i_tx_iack,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_send,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_ready,
  output logic        o_rx_clear
);

  typedef enum logic [1:0] {X_IDLE, X_SEND, X_WAIT} xstate_t;

  localparam logic [15:0] CNT_LAST = 16'(TX_TIMEOUT - 1);

  xstate_t     r_xstate, w_xstate_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [15:0] r_rdata, w_rd_mux;
  logic [7:0]  r_tx_data;
  logic        r_rie, r_xie, r_rx_clear;
  logic        r_rx_lvl, r_rx_lvl_d, r_rxp;
  logic        r_tx_lvl, r_tx_lvl_d, r_txp;

  logic w_wr, w_rd, w_rdy, w_xbuf_ok, w_rbuf_rd;
  logic w_rx_set, w_rx_clr, w_tx_set, w_tx_clr;
  logic w_unused_bits;

  assign w_wr      = i_sel & i_we & i_byte_en[0];
  assign w_rd      = i_sel & i_re;
  assign w_rdy     = (r_xstate == X_IDLE) & i_tx_ready;
  assign w_xbuf_ok = w_wr & (i_addr == 2'd3) & w_rdy;
  assign w_rbuf_rd = w_rd & (i_addr == 2'd1);

  // Two-stage level history gives a one-shot set on the rising edge of each condition
  assign w_rx_set = r_rx_lvl & ~r_rx_lvl_d;
  assign w_rx_clr = i_rx_iack | w_rbuf_rd | ~r_rie;
  assign w_tx_set = r_tx_lvl & ~r_tx_lvl_d;
  assign w_tx_clr = i_tx_iack | w_xbuf_ok | ~r_xie;

  assign w_unused_bits = ^{i_byte_en[1], i_wdata[15:8]};

  always_comb begin
    w_rd_mux = '0;
    case (i_addr)
      2'd0:    w_rd_mux = {8'h00, i_rx_data_ready, r_rie, 6'b0};
      2'd1:    w_rd_mux = {8'h00, i_rx_data};
      2'd2:    w_rd_mux = {8'h00, w_rdy, r_xie, 6'b0};
      default: w_rd_mux = '0;
    endcase
  end

  always_comb begin
    w_xstate_next = r_xstate;
    w_cnt_next    = r_cnt;
    o_tx_send     = 1'b0;
    case (r_xstate)
      X_IDLE: begin
        if (w_xbuf_ok) begin
          w_xstate_next = X_SEND;
          w_cnt_next    = '0;
        end
      end
      X_SEND: begin
        o_tx_send = 1'b1;
        if (!i_tx_ready || (r_cnt == CNT_LAST)) begin
          w_xstate_next = X_WAIT;
        end else if (r_cnt != 16'hFFFF) begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      X_WAIT: begin
        if (i_tx_ready) w_xstate_next = X_IDLE;
      end
      default: w_xstate_next = X_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xstate <= X_IDLE;
      r_cnt    <= '0;
    end else begin
      r_xstate <= w_xstate_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata    <= '0;
      r_tx_data  <= '0;
      r_rie      <= 1'b0;
      r_xie      <= 1'b0;
      r_rx_clear <= 1'b0;
    end else begin
      r_rx_clear <= w_rbuf_rd;
      if (w_rd) r_rdata <= w_rd_mux;
      if (w_wr && (i_addr == 2'd0)) r_rie <= i_wdata[6];
      if (w_wr && (i_addr == 2'd2)) r_xie <= i_wdata[6];
      if (w_xbuf_ok) r_tx_data <= i_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_lvl   <= 1'b0;
      r_rx_lvl_d <= 1'b0;
      r_rxp      <= 1'b0;
      r_tx_lvl   <= 1'b0;
      r_tx_lvl_d <= 1'b0;
      r_txp      <= 1'b0;
    end else begin
      r_rx_lvl   <= i_rx_data_ready & r_rie;
      r_rx_lvl_d <= r_rx_lvl;
      r_tx_lvl   <= w_rdy & r_xie;
      r_tx_lvl_d <= r_tx_lvl;
      if (w_rx_clr)      r_rxp <= 1'b0;
      else if (w_rx_set) r_rxp <= 1'b1;
      if (w_tx_clr)      r_txp <= 1'b0;
      else if (w_tx_set) r_txp <= 1'b1;
    end
  end

  assign o_rdata    = r_rdata;
  assign o_tx_data  = r_tx_data;
  assign o_rx_clear = r_rx_clear;
  assign o_rx_irq   = r_rxp;
  assign o_tx_irq   = r_txp;

endmodule

// File: tb/tb_dl11_uart_ctrl.sv
// Bench for dl11_uart_ctrl: directed bus/uart stimulus, a cycle model of the
// register block checked every cycle, plus hand-computed literal expectations.
module tb_dl11_uart_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_sel, i_re, i_we, i_rx_iack, i_tx_iack, i_tx_ready, i_rx_data_ready;
  logic [1:0]  i_addr, i_byte_en;
  logic [15:0] i_wdata;
  logic [7:0]  i_rx_data;
  logic [15:0] o_rdata;
  logic [7:0]  o_tx_data;
  logic        o_rx_irq, o_tx_irq, o_tx_send, o_rx_clear;

  int n_checks = 0;
  int n_pass   = 0;
  int send_cnt = 0;

  dl11_uart_ctrl #(.TX_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_sel(i_sel), .i_re(i_re), .i_we(i_we), .i_addr(i_addr),
    .i_byte_en(i_byte_en), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rx_irq(o_rx_irq), .o_tx_irq(o_tx_irq),
    .i_rx_iack(i_rx_iack), .i_tx_iack(i_tx_iack),
    .o_tx_data(o_tx_data), .o_tx_send(o_tx_send), .i_tx_ready(i_tx_ready),
    .i_rx_data(i_rx_data), .i_rx_data_ready(i_rx_data_ready),
    .o_rx_clear(o_rx_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) send_cnt <= send_cnt + int'(o_tx_send);

  // Behavioural model: transmitter phase 0=idle, 1=sending, 2=waiting for ready
  int          m_phase, m_cnt;
  logic [7:0]  m_txd;
  logic [15:0] m_rdata;
  logic        m_rxclr, m_rie, m_xie, m_rxp, m_txp;
  logic [1:0]  m_rh, m_th;
  logic        m_rdy, m_wr, m_rd, m_xbuf_ok;
  logic [15:0] m_regval;

  always_comb begin
    m_rdy     = (m_phase == 0) && i_tx_ready;
    m_wr      = i_sel && i_we && i_byte_en[0];
    m_rd      = i_sel && i_re;
    m_xbuf_ok = m_wr && (i_addr == 2'd3) && m_rdy;
    m_regval  = 16'h0000;
    if (i_addr == 2'd0) m_regval = (i_rx_data_ready ? 16'h0080 : 16'h0) | (m_rie ? 16'h0040 : 16'h0);
    if (i_addr == 2'd1) m_regval = {8'h00, i_rx_data};
    if (i_addr == 2'd2) m_regval = (m_rdy ? 16'h0080 : 16'h0) | (m_xie ? 16'h0040 : 16'h0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_cnt <= 0; m_txd <= 8'h00; m_rdata <= 16'h0000;
      m_rxclr <= 1'b0; m_rie <= 1'b0; m_xie <= 1'b0; m_rxp <= 1'b0; m_txp <= 1'b0;
      m_rh <= 2'b00; m_th <= 2'b00;
    end else begin
      m_rxclr <= m_rd && (i_addr == 2'd1);
      if (m_rd) m_rdata <= m_regval;
      if (m_wr && i_addr == 2'd0) m_rie <= i_wdata[6];
      if (m_wr && i_addr == 2'd2) m_xie <= i_wdata[6];
      if (m_xbuf_ok) m_txd <= i_wdata[7:0];
      if (m_phase == 0 && m_xbuf_ok) begin
        m_phase <= 1; m_cnt <= 0;
      end else if (m_phase == 1) begin
        if (!i_tx_ready || m_cnt == TO - 1) m_phase <= 2;
        else m_cnt <= m_cnt + 1;
      end else if (m_phase == 2 && i_tx_ready) begin
        m_phase <= 0;
      end
      m_rh <= {m_rh[0], i_rx_data_ready && m_rie};
      m_th <= {m_th[0], m_rdy && m_xie};
      if (i_rx_iack || (m_rd && i_addr == 2'd1) || !m_rie) m_rxp <= 1'b0;
      else if (m_rh[0] && !m_rh[1]) m_rxp <= 1'b1;
      if (i_tx_iack || m_xbuf_ok || !m_xie) m_txp <= 1'b0;
      else if (m_th[0] && !m_th[1]) m_txp <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("m_tx_send",  {15'b0, o_tx_send},  {15'b0, m_phase == 1});
      check("m_tx_data",  {8'b0, o_tx_data},   {8'b0, m_txd});
      check("m_rdata",    o_rdata,             m_rdata);
      check("m_rx_clear", {15'b0, o_rx_clear}, {15'b0, m_rxclr});
      check("m_rx_irq",   {15'b0, o_rx_irq},   {15'b0, m_rxp});
      check("m_tx_irq",   {15'b0, o_tx_irq},   {15'b0, m_txp});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d; i_byte_en = 2'b01;
    tick();
    i_sel = 1'b0; i_we = 1'b0; i_byte_en = 2'b00;
  endtask

  task automatic bus_read(input logic [1:0] a);
    i_sel = 1'b1; i_re = 1'b1; i_addr = a;
    tick();
    i_sel = 1'b0; i_re = 1'b0;
  endtask

  int n0;

  initial begin
    reset_n = 1'b0;
    i_sel = 1'b0; i_re = 1'b0; i_we = 1'b0; i_addr = 2'd0; i_byte_en = 2'b00;
    i_wdata = 16'h0000; i_rx_iack = 1'b0; i_tx_iack = 1'b0; i_tx_ready = 1'b1;
    i_rx_data = 8'h00; i_rx_data_ready = 1'b0;
    tick(); tick();
    check("reset_rdata", o_rdata, 16'h0000);
    check("reset_tx_send", {15'b0, o_tx_send}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // Transmit handshake: uart_tx drops ready one cycle into tx_send, returns 3 later
    n0 = send_cnt;
    bus_write(2'd3, 16'h0141);
    check("hs_tx_data", {8'b0, o_tx_data}, 16'h0041);
    check("hs_tx_send", {15'b0, o_tx_send}, 16'h0001);
    tick();
    i_tx_ready = 1'b0;
    bus_read(2'd2);
    check("hs_xcsr_busy", o_rdata, 16'h0000);
    bus_write(2'd3, 16'h0042);
    check("busy_tx_data", {8'b0, o_tx_data}, 16'h0041);
    check("busy_no_send", {15'b0, o_tx_send}, 16'h0000);
    tick();
    i_tx_ready = 1'b1;
    tick(); tick(); tick();
    check("hs_send_cycles", 16'(send_cnt - n0), 16'd2);
    check("busy_tx_data2", {8'b0, o_tx_data}, 16'h0041);
    bus_read(2'd2);
    check("hs_xcsr_idle", o_rdata, 16'h0080);

    // Transmit timeout with ready held high
    n0 = send_cnt;
    bus_write(2'd3, 16'h0055);
    tick(); tick(); tick(); tick();
    check("to_send_dropped", {15'b0, o_tx_send}, 16'h0000);
    check("to_send_cycles", 16'(send_cnt - n0), 16'd4);
    bus_read(2'd2);
    check("to_xcsr_wait", o_rdata, 16'h0000);
    bus_read(2'd2);
    check("to_xcsr_idle", o_rdata, 16'h0080);

    // Receive path
    bus_write(2'd0, 16'h0040);
    i_rx_data = 8'h5A; i_rx_data_ready = 1'b1;
    tick();
    check("rx_irq_1cyc", {15'b0, o_rx_irq}, 16'h0000);
    tick();
    check("rx_irq_2cyc", {15'b0, o_rx_irq}, 16'h0001);
    bus_read(2'd0);
    check("rx_rcsr", o_rdata, 16'h00C0);
    bus_read(2'd1);
    check("rx_rbuf", o_rdata, 16'h005A);
    check("rx_clear_pulse", {15'b0, o_rx_clear}, 16'h0001);
    check("rx_irq_cleared", {15'b0, o_rx_irq}, 16'h0000);
    tick();
    check("rx_clear_end", {15'b0, o_rx_clear}, 16'h0000);
    i_rx_data_ready = 1'b0;
    tick(); tick();
    check("rx_irq_stays", {15'b0, o_rx_irq}, 16'h0000);

    // Transmit interrupt
    bus_write(2'd2, 16'h0040);
    check("tx_irq_0", {15'b0, o_tx_irq}, 16'h0000);
    tick();
    check("tx_irq_1", {15'b0, o_tx_irq}, 16'h0000);
    tick();
    check("tx_irq_2", {15'b0, o_tx_irq}, 16'h0001);
    i_tx_iack = 1'b1;
    tick();
    i_tx_iack = 1'b0;
    check("tx_iack_clr", {15'b0, o_tx_irq}, 16'h0000);
    tick(); tick();
    check("tx_irq_held_low", {15'b0, o_tx_irq}, 16'h0000);
    bus_write(2'd3, 16'h0033);
    for (int i = 0; i < 6; i++) tick();
    check("tx_irq_busy", {15'b0, o_tx_irq}, 16'h0000);
    tick();
    check("tx_irq_rearm", {15'b0, o_tx_irq}, 16'h0001);
    bus_write(2'd2, 16'h0000);
    check("tx_xie0_same", {15'b0, o_tx_irq}, 16'h0001);
    tick();
    check("tx_xie0_next", {15'b0, o_tx_irq}, 16'h0000);

    // Reset mid-send
    bus_write(2'd2, 16'h0040);
    bus_read(2'd2);
    bus_write(2'd3, 16'h0077);
    check("pre_rst_send", {15'b0, o_tx_send}, 16'h0001);
    check("pre_rst_rdata", o_rdata, 16'h00C0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_tx_send", {15'b0, o_tx_send}, 16'h0000);
    check("rst_rdata", o_rdata, 16'h0000);
    check("rst_rx_irq", {15'b0, o_rx_irq}, 16'h0000);
    check("rst_tx_irq", {15'b0, o_tx_irq}, 16'h0000);
    check("rst_tx_data", {8'b0, o_tx_data}, 16'h0000);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    bus_read(2'd2);
    check("post_rst_xcsr", o_rdata, 16'h0080);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
